// File: rtl/sha256_compress.sv
// sha256_compress: iterative SHA-256 block compression, one round per clock,
// with internal message schedule and chaining state H0..H7.
module sha256_compress (
    input  logic         clk,
    input  logic         rst,
    input  logic         init,
    input  logic         block_valid,
    output logic         block_ready,
    input  logic [511:0] block,
    output logic [5:0]   k_addr,
    input  logic [31:0]  k_in,
    output logic         digest_valid,
    output logic [255:0] digest
);
    typedef enum logic [1:0] {IDLE, ROUNDS, FINAL} state_t;

    localparam logic [0:7][31:0] IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    state_t            state_q, state_d;
    logic [5:0]        t_q, t_d;
    logic [0:7][31:0]  hh_q, hh_d;
    logic [0:7][31:0]  v_q, v_d;
    logic [0:15][31:0] w_q, w_d;
    logic              dv_q, dv_d;
    logic [31:0]       t1, t2, wn;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // v_q holds a..h at indices 0..7
    always_comb begin
        t1 = v_q[7] + (rotr(v_q[4], 6) ^ rotr(v_q[4], 11) ^ rotr(v_q[4], 25))
           + ((v_q[4] & v_q[5]) ^ (~v_q[4] & v_q[6])) + k_in + w_q[0];
        t2 = (rotr(v_q[0], 2) ^ rotr(v_q[0], 13) ^ rotr(v_q[0], 22))
           + ((v_q[0] & v_q[1]) ^ (v_q[0] & v_q[2]) ^ (v_q[1] & v_q[2]));
        wn = (rotr(w_q[14], 17) ^ rotr(w_q[14], 19) ^ (w_q[14] >> 10)) + w_q[9]
           + (rotr(w_q[1], 7) ^ rotr(w_q[1], 18) ^ (w_q[1] >> 3)) + w_q[0];
    end

    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        hh_d    = hh_q;
        v_d     = v_q;
        w_d     = w_q;
        dv_d    = dv_q;
        case (state_q)
            IDLE: if (block_valid) begin
                state_d = ROUNDS;
                t_d     = 6'd0;
                dv_d    = 1'b0;
                hh_d    = init ? IV : hh_q;
                v_d     = init ? IV : hh_q;
                for (int i = 0; i < 16; i++) w_d[i] = block[511 - 32*i -: 32];
            end
            ROUNDS: begin
                v_d     = {t1 + t2, v_q[0], v_q[1], v_q[2], v_q[3] + t1, v_q[4], v_q[5], v_q[6]};
                w_d     = {w_q[1:15], wn};
                t_d     = t_q + 6'd1;
                state_d = (t_q == 6'd63) ? FINAL : ROUNDS;
            end
            FINAL: begin
                for (int i = 0; i < 8; i++) hh_d[i] = hh_q[i] + v_q[i];
                dv_d    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            t_q     <= 6'd0;
            hh_q    <= IV;
            v_q     <= '0;
            w_q     <= '0;
            dv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            hh_q    <= hh_d;
            v_q     <= v_d;
            w_q     <= w_d;
            dv_q    <= dv_d;
        end
    end

    assign block_ready  = (state_q == IDLE);
    assign k_addr       = t_q;
    assign digest_valid = dv_q;
    assign digest       = hh_q;
endmodule

// File: tb/tb_sha256_compress.sv
// tb_sha256_compress: directed known-answer tests for sha256_compress
// with a combinational K table supplied by the bench.
module tb_sha256_compress;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         init = 1'b0;
    logic         block_valid = 1'b0;
    logic         block_ready;
    logic [511:0] block = '0;
    logic [5:0]   k_addr;
    logic [31:0]  k_in;
    logic         digest_valid;
    logic [255:0] digest;
    int checks = 0;
    int errors = 0;

    localparam logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [255:0] IV    = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
    localparam logic [255:0] D_ABC = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
    localparam logic [255:0] D_EMP = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
    localparam logic [255:0] D_TWO = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

    localparam logic [511:0] B_ABC = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] B_EMP = {32'h80000000, 480'h0};
    localparam logic [511:0] B_TW1 = {
        32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667, 32'h65666768, 32'h66676869, 32'h6768696a,
        32'h68696a6b, 32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f, 32'h6d6e6f70, 32'h6e6f7071,
        32'h80000000, 32'h00000000
    };
    localparam logic [511:0] B_TW2 = {480'h0, 32'h000001c0};

    assign k_in = K[k_addr];

    always #5 clk = ~clk;

    sha256_compress dut (
        .clk(clk), .rst(rst), .init(init), .block_valid(block_valid), .block_ready(block_ready),
        .block(block), .k_addr(k_addr), .k_in(k_in), .digest_valid(digest_valid), .digest(digest)
    );

    // Called at a negedge with block_ready high; returns at the negedge where ready rises again.
    task automatic run_block(input logic [511:0] b, input logic ini, input bit noise, input bit chk_k, output int cnt);
        block_valid = 1'b1;
        block = b;
        init = ini;
        @(negedge clk);
        block_valid = 1'b0;
        checks++;
        if (digest_valid !== 1'b0) begin
            errors++;
            $display("FAIL accept_clears_valid got %b want 0", digest_valid);
        end
        cnt = 0;
        while (block_ready !== 1'b1 && cnt < 300) begin
            if (chk_k) begin
                checks++;
                if (k_addr !== 6'(cnt)) begin
                    errors++;
                    $display("FAIL k_addr_seq step %0d got %0d want %0d", cnt, k_addr, 6'(cnt));
                end
            end
            if (noise) begin
                block_valid = 1'($urandom_range(0, 1));
                block = {16{$urandom()}};
                init = 1'($urandom_range(0, 1));
            end
            cnt++;
            @(negedge clk);
        end
        block_valid = 1'b0;
    endtask

    task automatic check_result(input string name, input int cnt, input logic [255:0] exp);
        checks++;
        if (cnt !== 65) begin
            errors++;
            $display("FAIL %s_busy_cycles got %0d want 65", name, cnt);
        end
        checks++;
        if (digest_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s_digest_valid got %b want 1", name, digest_valid);
        end
        checks++;
        if (digest !== exp) begin
            errors++;
            $display("FAIL %s_digest got %h want %h", name, digest, exp);
        end
    endtask

    task automatic check_idle_reset(input string name);
        checks++;
        if (block_ready !== 1'b1) begin errors++; $display("FAIL %s_ready got %b want 1", name, block_ready); end
        checks++;
        if (digest_valid !== 1'b0) begin errors++; $display("FAIL %s_valid got %b want 0", name, digest_valid); end
        checks++;
        if (digest !== IV) begin errors++; $display("FAIL %s_digest got %h want %h", name, digest, IV); end
        checks++;
        if (k_addr !== 6'd0) begin errors++; $display("FAIL %s_k_addr got %0d want 0", name, k_addr); end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_idle_reset("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        check_idle_reset("reset_idle");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_abc();
        int cnt;
        run_block(B_ABC, 1'b1, 1'b0, 1'b1, cnt);
        check_result("abc", cnt, D_ABC);
        repeat (3) @(negedge clk);
        checks++;
        if (digest_valid !== 1'b1 || digest !== D_ABC) begin
            errors++;
            $display("FAIL abc_hold valid=%b digest=%h want 1 %h", digest_valid, digest, D_ABC);
        end
    endtask

    task automatic test_empty();
        int cnt;
        run_block(B_EMP, 1'b1, 1'b0, 1'b0, cnt);
        check_result("empty", cnt, D_EMP);
    endtask

    task automatic test_back_to_back();
        int cnt;
        run_block(B_TW1, 1'b1, 1'b0, 1'b0, cnt);
        checks++;
        if (cnt !== 65) begin errors++; $display("FAIL two_blk1_busy_cycles got %0d want 65", cnt); end
        checks++;
        if (digest_valid !== 1'b1) begin errors++; $display("FAIL two_blk1_valid got %b want 1", digest_valid); end
        run_block(B_TW2, 1'b0, 1'b0, 1'b0, cnt);
        check_result("two_blk2", cnt, D_TWO);
    endtask

    task automatic test_ignore_inputs();
        int cnt;
        run_block(B_ABC, 1'b1, 1'b1, 1'b0, cnt);
        check_result("noise_abc", cnt, D_ABC);
        @(negedge clk);
        checks++;
        if (block_ready !== 1'b1 || digest !== D_ABC) begin
            errors++;
            $display("FAIL noise_after ready=%b digest=%h want 1 %h", block_ready, digest, D_ABC);
        end
    endtask

    task automatic test_reset_mid();
        int cnt;
        block_valid = 1'b1;
        block = B_ABC;
        init = 1'b1;
        @(negedge clk);
        block_valid = 1'b0;
        repeat (30) @(negedge clk);
        checks++;
        if (block_ready !== 1'b0 || k_addr !== 6'd30) begin
            errors++;
            $display("FAIL mid_round ready=%b k_addr=%0d want 0 30", block_ready, k_addr);
        end
        rst = 1'b1;
        #1;
        check_idle_reset("reset_mid");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_block(B_ABC, 1'b0, 1'b0, 1'b0, cnt);
        check_result("abc_after_reset", cnt, D_ABC);
    endtask

    initial begin
        test_reset();
        test_abc();
        test_empty();
        test_back_to_back();
        test_ignore_inputs();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sha256_compress.md
Name: sha256_compress

Overview:
- Iterative SHA-256 compression engine, one round per clock.
- Accepts one 512-bit padded message block per handshake and expands the message schedule internally.
- Drives the round index to the combinational K-constant table and consumes the returned K word in the same cycle.
- Maintains the chaining state H0..H7 across blocks and presents the 256-bit digest to the downstream hash controller.

Parameters:
- None. Word width 32, block 512, digest 256 and round count 64 are fixed by FIPS 180-4.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- init  input  1  sampled only at block accept. 1 = start a new message from the IV; 0 = chain from the current H.
- block_valid  input  1  upstream offers block.
- block_ready  output  1  engine idle and able to accept.
- block  input  512  message block; word W0 = block[511:480], W15 = block[31:0].
- k_addr  output  6  round index to the K table.
- k_in  input  32  K[k_addr] from the table, combinational, same cycle.
- digest_valid  output  1  digest holds the result of the last accepted block.
- digest  output  256  H0 in [255:224] … H7 in [31:0].

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - state=IDLE, round counter t=0, block_ready=1, digest_valid=0, k_addr=0.
  - H0..H7 = IV (6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19), so digest = IV.
  - Working registers a..h and the W window are cleared to 0.
- States:
  - IDLE: block_ready=1. On block_valid&block_ready, go to ROUNDS.
  - ROUNDS: block_ready=0. After the round with t==63, go to FINAL.
  - FINAL: block_ready=0. Unconditionally return to IDLE.
- Accept edge (IDLE):
  - W window[0..15] <= block words.
  - If init=1, H <= IV and a..h <= IV. Otherwise a..h <= current H.
  - t <= 0; digest_valid <= 0.
- ROUNDS, each edge, using the current t:
  - k_addr = t (registered counter, no combinational path from inputs).
  - T1 = h + Σ1(e) + Ch(e,f,g) + k_in + window[0].
  - T2 = Σ0(a) + Maj(a,b,c).
  - Update: h<=g, g<=f, f<=e, e<=d+T1, d<=c, c<=b, b<=a, a<=T1+T2.
  - Window shifts down one word: window[i] <= window[i+1].
  - New window[15] <= σ1(window[14]) + window[9] + σ0(window[1]) + window[0], computed every round; words produced after round 47 are unused.
  - t <= t+1, 6-bit; t wraps to 0 on the t==63 edge.
- FINAL edge: Hi <= Hi + working register i for all eight words; digest_valid <= 1.
- Functions:
  - Σ0 = ROTR2^ROTR13^ROTR22; Σ1 = ROTR6^ROTR11^ROTR25.
  - σ0 = ROTR7^ROTR18^SHR3; σ1 = ROTR17^ROTR19^SHR10.
  - All additions are modulo 2^32, carries discarded.
- Latency:
  - Accept at edge E0; rounds at E1..E64; H update at E65.
  - digest_valid=1 and block_ready=1 after E65, i.e. 65 cycles from accept to result.
  - Back-to-back throughput: one block per 66 cycles.
- digest_valid: level signal. Stays high in IDLE until the next accept edge clears it; digest value is stable meanwhile.
- Inputs ignored outside IDLE: block_valid, block and init have no effect during ROUNDS and FINAL; no buffering.
- Reset mid-operation: immediately restores reset values; the partial block is discarded and H returns to IV.
- Simultaneous accept while digest_valid=1: accept wins; digest_valid falls, and digest (= H) keeps its old value until E65.

Test Plan:
- Reset then idle → block_ready=1, digest_valid=0, digest=IV, k_addr=0; assert rst mid-idle → values unchanged.
- "abc": block = 61626380, 14×00000000, 00000018, init=1 → after 65 cycles digest = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
- Empty message: block = 80000000 followed by 15 zero words, init=1 → e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
- Two-block "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq": block1 init=1, block2 init=0, block2 offered the same cycle digest_valid rises → final digest 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1; block_ready low for exactly 65 cycles per block.
- Monitor k_addr during ROUNDS → exact sequence 0..63, then 0. Toggle block_valid, block and init during ROUNDS → digest unchanged vs. the clean run.
- Assert rst at round 30 of "abc", then re-send "abc" with init=0 → same "abc" digest, because H restarts from IV.
